// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter: pops one byte per frame through the FIFO
// read handshake and shifts it out as start, 8 data bits LSB first, parity, stop.
`timescale 1ns/1ps

module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       en,
  input  logic       Fempty,
  input  logic [7:0] Din,
  output logic       Ren,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] BIT_LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic        HAS_PARITY = (PARITY != 0);
  localparam logic        ODD_PARITY = (PARITY == 2);
  localparam logic        TWO_STOP   = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t      state_q;
  logic [15:0] timer_q;
  logic [15:0] timer_d;
  logic        bit_end;
  logic [2:0]  idx_q;
  logic [7:0]  shreg_q;
  logic        par_q;
  logic        stop2_q;
  logic        txd_q;
  logic        ren_q;
  logic        busy_q;
  logic        done_q;
  logic        start_ok;

  assign start_ok = en && !Fempty;

  // The bit timer only runs while a serial bit is on the line.
  always_comb begin
    bit_end = (timer_q == BIT_LAST);
    timer_d = 16'd0;
    if (state_q inside {S_START, S_DATA, S_PAR, S_STOP}) begin
      timer_d = bit_end ? 16'd0 : timer_q + 16'd1;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= 16'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'd0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      txd_q   <= 1'b1;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      ren_q   <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q <= 1'b1;
          if (start_ok) begin
            state_q <= S_FETCH;
            ren_q   <= 1'b1;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        // Din holds the popped byte during this cycle.
        S_LOAD: begin
          shreg_q <= Din;
          par_q   <= ^Din;
          txd_q   <= 1'b0;
          state_q <= S_START;
        end
        S_START: begin
          if (bit_end) begin
            state_q <= S_DATA;
            idx_q   <= 3'd0;
            txd_q   <= shreg_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (idx_q == 3'd7) begin
              idx_q <= 3'd0;
              if (HAS_PARITY) begin
                state_q <= S_PAR;
                txd_q   <= par_q ^ ODD_PARITY;
              end else begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
                stop2_q <= 1'b0;
              end
            end else begin
              idx_q <= idx_q + 3'd1;
              txd_q <= shreg_q[idx_q + 3'd1];
            end
          end
        end
        S_PAR: begin
          if (bit_end) begin
            state_q <= S_STOP;
            txd_q   <= 1'b1;
            stop2_q <= 1'b0;
          end
        end
        // Last stop cycle doubles as the start decision for the next frame.
        S_STOP: begin
          if (bit_end) begin
            if (TWO_STOP && !stop2_q) begin
              stop2_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
              if (start_ok) begin
                state_q <= S_FETCH;
                ren_q   <= 1'b1;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Ren  = ren_q;
  assign txd  = txd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
